sr_latch_sequencer: RTL and testbench

- Shares a bank of NLATCH cross-coupled NOR SR latches between NREQ requesters.
- Requesters ask to set or clear one latch. A round-robin arbiter picks one request, then the block drives a fixed-width S or R pulse to that latch.
- After the pulse, a guard gap lets the latch settle, then the block reads Q back and reports done/err.
- The block guarantees S and R are never both high on any latch, and at most one latch is driven at a time.

---
 rtl/sr_latch_sequencer.sv | 143 ++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sr_latch_sequencer.sv
// Round-robin sequencer that shares a bank of NOR SR latches between requesters:
// it drives one S or R pulse, waits out a settle gap, then reads Q back.
module sr_latch_sequencer #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NLATCH  = 8,
  parameter int unsigned IDXW    = 3,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NLATCH-1:0]    S,
  output logic [NLATCH-1:0]    R,
  input  logic [NLATCH-1:0]    Q,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int unsigned CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

  state_t            state;
  logic [PTRW-1:0]   ptr;
  logic [PTRW-1:0]   ptr_nxt;
  logic [PTRW-1:0]   sel;
  logic              found;
  int unsigned       cand;
  logic [NREQ-1:0]   sel_gnt;
  logic              sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic [NLATCH-1:0] sel_mask;
  logic              sel_bad;
  logic [CNTW-1:0]   cnt;
  logic              op_r;
  logic              bad;
  logic [NLATCH-1:0] mask;

  // Rotating priority scan: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[PTRW'(cand)]) begin
        sel   = PTRW'(cand);
        found = 1'b1;
      end
    end

    ptr_nxt = (32'(sel) + 1 >= NREQ) ? '0 : sel + PTRW'(1);

    sel_gnt = '0;
    sel_op  = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PTRW'(i) == sel) begin
        sel_gnt[i] = found;
        sel_op     = req_op[i];
        sel_idx    = req_idx[i*IDXW +: IDXW];
      end
    end

    // An index beyond the bank decodes to an empty mask, so nothing is driven.
    sel_mask = '0;
    for (int unsigned i = 0; i < NLATCH; i++) begin
      sel_mask[i] = (sel_idx == IDXW'(i));
    end
    sel_bad = ({1'b0, sel_idx} >= (IDXW+1)'(NLATCH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      op_r  <= 1'b0;
      bad   <= 1'b0;
      mask  <= '0;
      gnt   <= '0;
      S     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= PULSE;
            gnt   <= sel_gnt;
            ptr   <= ptr_nxt;
            op_r  <= sel_op;
            mask  <= sel_mask;
            bad   <= sel_bad;
            S     <= sel_op ? sel_mask : '0;
            R     <= sel_op ? '0 : sel_mask;
            cnt   <= CNTW'(PULSE_W - 1);
            busy  <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            S     <= '0;
            R     <= '0;
            state <= GAP;
            cnt   <= CNTW'(GAP_W - 1);
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        GAP: begin
          // Readback is latched on entry to CHECK so done/err stay registered.
          if (cnt == '0) begin
            state <= CHECK;
            done  <= 1'b1;
            err   <= bad | ((|(Q & mask)) != op_r);
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        CHECK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Directed bench for sr_latch_sequencer with a behavioural latch-bank model
// and per-cycle invariant checks on the drive outputs.
module tb_sr_latch_sequencer;

  localparam int NL = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  req_op;
  logic [11:0] req_idx;
  logic [3:0]  gnt;
  logic [NL-1:0] S, R, Q;
  logic        busy, done, err;

  logic [NL-1:0] q_model;
  logic [NL-1:0] force0;
  logic [18:0]   obs;
  logic [3:0]    inv_flags;
  bit            inv_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  sr_latch_sequencer #(
    .NREQ(4), .NLATCH(NL), .IDXW(3), .PULSE_W(2), .GAP_W(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
    .gnt(gnt), .S(S), .R(R), .Q(Q), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) q_model <= '0;
    else     q_model <= (q_model | S) & ~R;
  end
  assign Q   = q_model & ~force0;
  assign obs = {gnt, S, R, busy, done, err};
  assign inv_flags = {|(S & R), ($countones(S | R) > 1), ($countones(gnt) > 1),
                      done && (|(S | R))};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] ev(input logic [3:0] g, input logic [NL-1:0] s,
                                     input logic [NL-1:0] r, input logic b,
                                     input logic d, input logic e);
    return {g, s, r, b, d, e};
  endfunction

  always @(negedge clk) begin
    if (inv_en) check("invariant", {28'b0, inv_flags}, 32'd0);
  end

  task automatic set_req(input int i, input logic op, input logic [2:0] idx);
    req[i]            = 1'b1;
    req_op[i]         = op;
    req_idx[i*3 +: 3] = idx;
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_hold", {13'b0, obs}, 32'd0);
    rst = 1'b0;
  endtask

  // Called at the negedge of the arbitration cycle (cycle 0); returns at cycle 5.
  task automatic run_op(input int g, input logic op, input int idx,
                        input logic err_exp, input logic [3:0] drop);
    logic [NL-1:0] m;
    logic [3:0]    gm;
    logic [18:0]   exp;
    m  = (idx < NL) ? NL'(1 << idx) : '0;
    gm = 4'(1 << g);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      case (c)
        1:       exp = ev(gm,   op ? m : '0, op ? '0 : m, 1'b1, 1'b0, 1'b0);
        2:       exp = ev(4'b0, op ? m : '0, op ? '0 : m, 1'b1, 1'b0, 1'b0);
        3:       exp = ev(4'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        4:       exp = ev(4'b0, '0, '0, 1'b1, 1'b1, err_exp);
        default: exp = '0;
      endcase
      check($sformatf("op_g%0d_idx%0d_c%0d", g, idx, c), {13'b0, obs}, {13'b0, exp});
      if (c == 1) req = req & ~drop;
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_idx = '0; force0 = '0;
    @(negedge clk);
    check("reset_state", {13'b0, obs}, 32'd0);
    inv_en = 1'b1;
    @(negedge clk);
    check("reset_state2", {13'b0, obs}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle", {13'b0, obs}, 32'd0);
    end

    // single set, then a clear of the same latch from requester 3 (pointer is 1)
    set_req(0, 1'b1, 3'd5);
    run_op(0, 1'b1, 5, 1'b0, 4'b0001);
    set_req(3, 1'b0, 3'd5);
    run_op(3, 1'b0, 5, 1'b0, 4'b1000);

    // round-robin with all requesters held high
    do_reset();
    set_req(0, 1'b0, 3'd2);
    set_req(1, 1'b0, 3'd3);
    set_req(2, 1'b0, 3'd4);
    set_req(3, 1'b0, 3'd1);
    run_op(0, 1'b0, 2, 1'b0, 4'b0000);
    run_op(1, 1'b0, 3, 1'b0, 4'b0000);
    run_op(2, 1'b0, 4, 1'b0, 4'b0000);
    run_op(3, 1'b0, 1, 1'b0, 4'b0000);
    run_op(0, 1'b0, 2, 1'b0, 4'b1111);

    // readback failure: latch 3 stuck low
    do_reset();
    force0 = 6'b001000;
    set_req(2, 1'b1, 3'd3);
    run_op(2, 1'b1, 3, 1'b1, 4'b0100);
    force0 = '0;

    // index beyond the bank
    do_reset();
    set_req(1, 1'b1, 3'd7);
    run_op(1, 1'b1, 7, 1'b1, 4'b0010);

    // reset during the pulse; req[3] pending exposes a stale pointer
    do_reset();
    set_req(1, 1'b1, 3'd1);
    set_req(3, 1'b1, 3'd4);
    @(negedge clk);
    check("midrst_pulse", {13'b0, obs}, {13'b0, ev(4'b0010, 6'b000010, '0, 1'b1, 1'b0, 1'b0)});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_clear", {13'b0, obs}, 32'd0);
    rst = 1'b0;
    run_op(1, 1'b1, 1, 1'b0, 4'b0010);
    run_op(3, 1'b1, 4, 1'b0, 4'b1000);

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
